// File: rtl/bin2bcd_if.sv
// bin2bcd_if: control and data bundle between a binary source and bin2bcd_seq.
interface bin2bcd_if #(parameter int IN_WIDTH = 14);
  logic enable;
  logic start;
  logic [IN_WIDTH-1:0] bin_in;
  logic [15:0] bcd_out;
  logic busy;
  logic done;
  logic overflow;
  modport master (output enable, start, bin_in, input bcd_out, busy, done, overflow);
  modport slave (input enable, start, bin_in, output bcd_out, busy, done, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-cycle shift/add-3 binary to packed 4-digit BCD converter.
// Define BIN2BCD_LEADING_BLANK_EN to replace leading zero digits with the blank code 4'hF.
module bin2bcd_seq #(
  parameter int IN_WIDTH = 14,
  parameter logic [15:0] SAT_BCD = 16'h9999
) (
  input logic clk,
  input logic reset,
  bin2bcd_if.slave bus
);
  localparam int CW = $clog2(IN_WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q;
  logic [IN_WIDTH-1:0] sh_q;
  logic [15:0] scr_q, adj, res_d, bcd_q;
  logic [CW-1:0] cnt_q;
  logic busy_q, done_q, ovf_q, ovc_q;
  // Per-nibble add-3 with no carry between digits; the shift below does the carrying.
  always_comb begin
    for (int i = 0; i < 4; i++)
      adj[4*i+:4] = (scr_q[4*i+:4] >= 4'd5) ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
  end
`ifdef BIN2BCD_LEADING_BLANK_EN
  logic z3, z2, z1;
  assign z3 = scr_q[15:12] == 4'd0;
  assign z2 = z3 && scr_q[11:8] == 4'd0;
  assign z1 = z2 && scr_q[7:4] == 4'd0;
  assign res_d = ovc_q ? SAT_BCD : {z3 ? 4'hF : scr_q[15:12], z2 ? 4'hF : scr_q[11:8],
                                    z1 ? 4'hF : scr_q[7:4], scr_q[3:0]};
`else
  assign res_d = ovc_q ? SAT_BCD : scr_q;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      ovc_q <= 1'b0;
    end else if (bus.enable) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= bus.start;
          if (bus.start) begin
            sh_q <= bus.bin_in;
            scr_q <= '0;
            cnt_q <= CW'(IN_WIDTH - 1);
            ovc_q <= 32'(bus.bin_in) > 32'd9999;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {scr_q, sh_q} <= {adj, sh_q} << 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= DONE;
        end
        DONE: begin
          bcd_q <= res_d;
          ovf_q <= ovc_q;
          done_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.bcd_out = bcd_q;
  assign bus.busy = busy_q;
  // A pending done is held back while the clock enable is low.
  assign bus.done = done_q & bus.enable;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed-vector bench for bin2bcd_seq.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  bin2bcd_if #(.IN_WIDTH(14)) bus ();
  bin2bcd_seq #(.IN_WIDTH(14), .SAT_BCD(16'h9999)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic launch(input logic [13:0] v);
    bus.start = 1'b1;
    bus.bin_in = v;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.bcd_out, bus.busy, bus.done, bus.overflow} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", {bus.bcd_out, bus.busy, bus.done, bus.overflow});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    launch(14'd1234);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    wait_done(0, lat);
    n_vec++;
    if (lat !== 15) begin n_err++; $display("FAIL basic_latency: got %0d expected 15", lat); end
    n_vec++;
    if (bus.bcd_out !== 16'h1234) begin n_err++; $display("FAIL basic_bcd: got %h expected 1234", bus.bcd_out); end
    n_vec++;
    if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %b expected 0", bus.overflow); end
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_done: got %b expected 1", bus.busy); end
    @(negedge clk);
    n_vec++;
    if ({bus.done, bus.busy} !== 2'b00) begin n_err++; $display("FAIL basic_after: got %b expected 00", {bus.done, bus.busy}); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic held;
    launch(14'd0);
    wait_done(0, lat);
    n_vec++;
    if (lat !== 15 || bus.bcd_out !== 16'h0000) begin
      n_err++;
      $display("FAIL b2b_zero: got lat %0d bcd %h expected lat 15 bcd 0000", lat, bus.bcd_out);
    end
    launch(14'd9999);
    n_vec++;
    if ({bus.busy, bus.done} !== 2'b10) begin n_err++; $display("FAIL b2b_accept: got %b expected 10", {bus.busy, bus.done}); end
    held = 1'b1;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.bcd_out !== 16'h0000) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (!held) begin n_err++; $display("FAIL b2b_hold: got changing bcd_out expected stable 0000"); end
    n_vec++;
    if (lat !== 15 || bus.bcd_out !== 16'h9999) begin
      n_err++;
      $display("FAIL b2b_nines: got lat %0d bcd %h expected lat 15 bcd 9999", lat, bus.bcd_out);
    end
  endtask

  task automatic test_overflow();
    int lat;
    launch(14'd12000);
    wait_done(0, lat);
    n_vec++;
    if (bus.bcd_out !== 16'h9999 || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sat: got bcd %h ovf %b expected bcd 9999 ovf 1", bus.bcd_out, bus.overflow);
    end
    launch(14'd7);
    bus.bin_in = 14'd12000;
    wait_done(0, lat);
    n_vec++;
    if (bus.bcd_out !== 16'h0007 || bus.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got bcd %h ovf %b expected bcd 0007 ovf 0", bus.bcd_out, bus.overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int lat;
    launch(14'd4321);
    repeat (4) @(negedge clk);
    launch(14'd1111);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %b expected 1", bus.busy); end
    wait_done(5, lat);
    n_vec++;
    if (lat !== 15 || bus.bcd_out !== 16'h4321) begin
      n_err++;
      $display("FAIL ign_result: got lat %0d bcd %h expected lat 15 bcd 4321", lat, bus.bcd_out);
    end
    @(negedge clk);
  endtask

  task automatic test_enable_stall();
    int lat;
    logic quiet;
    launch(14'd5678);
    repeat (3) @(negedge clk);
    bus.enable = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.bcd_out !== 16'h4321) quiet = 1'b0;
    end
    bus.enable = 1'b1;
    n_vec++;
    if (!quiet) begin n_err++; $display("FAIL stall_quiet: got done/bcd activity expected none"); end
    wait_done(13, lat);
    n_vec++;
    if (lat !== 25 || bus.bcd_out !== 16'h5678) begin
      n_err++;
      $display("FAIL stall_result: got lat %0d bcd %h expected lat 25 bcd 5678", lat, bus.bcd_out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    launch(14'd3333);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({bus.bcd_out, bus.busy, bus.done, bus.overflow} !== 19'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got %h expected 0", {bus.bcd_out, bus.busy, bus.done, bus.overflow});
    end
    wait_done(0, lat);
    n_vec++;
    if (lat < 30) begin n_err++; $display("FAIL abort_nodone: got done after %0d cycles expected none", lat); end
  endtask

  task automatic test_blank();
    logic [13:0] vin [4] = '{14'd42, 14'd0, 14'd1000, 14'd12000};
`ifdef BIN2BCD_LEADING_BLANK_EN
    logic [15:0] vexp [4] = '{16'hFF42, 16'hFFF0, 16'h1000, 16'h9999};
`else
    logic [15:0] vexp [4] = '{16'h0042, 16'h0000, 16'h1000, 16'h9999};
`endif
    int lat;
    for (int i = 0; i < 4; i++) begin
      launch(vin[i]);
      wait_done(0, lat);
      n_vec++;
      if (bus.bcd_out !== vexp[i]) begin
        n_err++;
        $display("FAIL blank_%0d: got %h expected %h", vin[i], bus.bcd_out, vexp[i]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.start = 1'b0;
    bus.bin_in = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_start_ignored();
    test_enable_stall();
    test_reset_abort();
    test_blank();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
